// File: rtl/io_input_port_pkg.sv
// io_input_port_pkg: register offsets and sizing helpers shared by the input port (rev 1.0)
`default_nettype none

package io_input_port_pkg;

  localparam logic [1:0] IO_SW_OFS   = 2'd0;
  localparam logic [1:0] IO_BTN_OFS  = 2'd1;
  localparam logic [1:0] IO_EVT_OFS  = 2'd2;
  localparam logic [1:0] IO_CTRL_OFS = 2'd3;

  function automatic int io_db_cnt_w(input int db_cycles);
    return (db_cycles < 2) ? 1 : $clog2(db_cycles);
  endfunction

endpackage

`default_nettype wire

// File: rtl/io_debounce.sv
// io_debounce: 2-flop synchroniser plus counter debouncer for one raw pad bit (rev 1.0)
`default_nettype none

module io_debounce
  import io_input_port_pkg::*;
#(
  parameter int DB_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic level_o
);

  localparam int CW = io_db_cnt_w(DB_CYCLES);
  localparam logic [CW-1:0] C_CNT_MAX = CW'(DB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          stable_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // A bounce back to the stable level clears the count, so partial runs never accumulate.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == C_CNT_MAX) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level_o = stable_q;

endmodule

`default_nettype wire

// File: rtl/io_input_port.sv
// io_input_port: memory-mapped switch/button reader with sticky events; IO_IRQ_EN adds CTRL mask and irq (rev 1.0)
`default_nettype none

module io_input_port
  import io_input_port_pkg::*;
#(
  parameter int DB_CYCLES = 100000,
  parameter int NSW       = 16,
  parameter int NBTN      = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NSW-1:0]  sw_raw,
  input  logic [NBTN-1:0] btn_raw,
  input  logic            sel,
  input  logic            we,
  input  logic [1:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            irq
);

  localparam int NEVT = NBTN + 1;
  // Warm-up spans the first settle after reset (sync + debounce + edge detect).
  localparam int WW = $clog2(DB_CYCLES + 4);
  localparam logic [WW-1:0] C_WARM_DONE = WW'(DB_CYCLES + 3);

  logic [NSW-1:0]  sw_lvl;
  logic [NBTN-1:0] btn_lvl;
  logic [NSW-1:0]  sw_prev_q;
  logic [NBTN-1:0] btn_prev_q;
  logic [WW-1:0]   warm_q;
  logic [WW-1:0]   warm_d;
  logic [NEVT-1:0] evt_q;
  logic [NEVT-1:0] evt_d;
  logic [NEVT-1:0] evt_set;
  logic [NEVT-1:0] evt_clr;
  logic [NEVT-1:0] mask_w;
  logic            ready;
  logic            wr_en;
  logic            unused_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < NSW; gi++) begin : g_sw
      io_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
        .clk     (clk),
        .reset_n (reset_n),
        .raw_i   (sw_raw[gi]),
        .level_o (sw_lvl[gi])
      );
    end
    for (gi = 0; gi < NBTN; gi++) begin : g_btn
      io_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
        .clk     (clk),
        .reset_n (reset_n),
        .raw_i   (btn_raw[gi]),
        .level_o (btn_lvl[gi])
      );
    end
  endgenerate

  assign ready        = (warm_q == C_WARM_DONE);
  assign warm_d       = ready ? warm_q : warm_q + 1'b1;
  assign wr_en        = sel & we;
  assign unused_wdata = &{1'b0, wdata[31:NEVT]};

  // Inputs already high at reset release settle during warm-up and raise no event.
  always_comb begin
    evt_set = '0;
    evt_clr = '0;
    if (ready) begin
      evt_set[NBTN-1:0] = btn_lvl & ~btn_prev_q;
      evt_set[NBTN]     = |(sw_lvl ^ sw_prev_q);
    end
    if (wr_en && (addr == IO_EVT_OFS)) begin
      evt_clr = wdata[NEVT-1:0];
    end
    evt_d = (evt_q & ~evt_clr) | evt_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_prev_q  <= '0;
      btn_prev_q <= '0;
      warm_q     <= '0;
      evt_q      <= '0;
    end else begin
      sw_prev_q  <= sw_lvl;
      btn_prev_q <= btn_lvl;
      warm_q     <= warm_d;
      evt_q      <= evt_d;
    end
  end

`ifdef IO_IRQ_EN
  logic [NEVT-1:0] mask_q;
  logic            irq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_en && (addr == IO_CTRL_OFS)) begin
        mask_q <= wdata[NEVT-1:0];
      end
      irq_q <= |(evt_q & mask_q);
    end
  end

  assign mask_w = mask_q;
  assign irq    = irq_q;
`else
  assign mask_w = '0;
  assign irq    = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr)
        IO_SW_OFS:   rdata[NSW-1:0]  = sw_lvl;
        IO_BTN_OFS:  rdata[NBTN-1:0] = btn_lvl;
        IO_EVT_OFS:  rdata[NEVT-1:0] = evt_q;
        IO_CTRL_OFS: rdata[NEVT-1:0] = mask_w;
        default:     rdata = '0;
      endcase
    end
  end

endmodule

`default_nettype wire
